// File: rtl/scandoubler_pkg.sv
// Shared types and constants for the scandoubler divider controller.
package scandoubler_pkg;

  localparam int DIV_W   = 4;
  localparam int DEF_DIV = 3;

  typedef enum logic [2:0] {
    NOSIG,
    MEASURE,
    SEARCH,
    APPLY,
    LOCKED
  } state_t;

endpackage

// File: rtl/scandoubler_divider_ctrl_search.sv
// Iterative divider search: finds the smallest d in [MIN_DIV, MAX_DIV] with LINE_PIXELS_MAX*(d+1) > ps.
// One candidate per cycle; done is a combinational strobe while d_out holds the result.
module sd_div_search #(
  parameter int PW              = 13,
  parameter int LINE_PIXELS_MAX = 512,
  parameter int MIN_DIV         = 1,
  parameter int MAX_DIV         = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [PW-1:0] ps,
  output logic          done,
  output logic [3:0]    d_out
);

  localparam int AW = PW + 5;

  logic          busy;
  logic [3:0]    d;
  logic [AW-1:0] acc;
  logic [AW-1:0] ps_q;

  assign done  = busy && ((acc > ps_q) || (d == 4'(MAX_DIV)));
  assign d_out = d;

  // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      d    <= 4'(MIN_DIV);
      acc  <= '0;
      ps_q <= '0;
    end else if (start) begin
      busy <= 1'b1;
      d    <= 4'(MIN_DIV);
      acc  <= AW'(LINE_PIXELS_MAX * (MIN_DIV + 1));
      ps_q <= AW'(ps);
    end else if (abort || done) begin
      busy <= 1'b0;
    end else if (busy) begin
      d   <= d + 4'd1;
      acc <= acc + AW'(LINE_PIXELS_MAX);
    end
  end

endmodule

// File: rtl/scandoubler_divider_ctrl.sv
// Automatic ce_divider selection for scandoubler_framing from the measured hsync period.
// Build option SD_DIVCTRL_VB_GATE_EN: divider changes only land on hsync edges during vblank.
module scandoubler_divider_ctrl #(
  parameter int HSCNT_WIDTH     = 12,
  parameter int LINE_PIXELS_MAX = 512,
  parameter int MIN_DIV         = 1,
  parameter int MAX_DIV         = 15,
  parameter int DEF_DIV         = scandoubler_pkg::DEF_DIV,
  parameter int MIN_LINE        = 32,
  parameter int TOL             = 4,
  parameter int STABLE_LINES    = 4
) (
  input  logic                                 clk_sys,
  input  logic                                 reset,
  input  logic                                 hs_in,
  input  logic                                 vb_in,
  output logic [scandoubler_pkg::DIV_W-1:0]    ce_divider,
  output logic                                 locked,
  output logic                                 no_signal,
  output logic [HSCNT_WIDTH:0]                 line_len,
  output logic                                 div_changed
);

  import scandoubler_pkg::*;

  localparam int CW = HSCNT_WIDTH + 1;
  localparam int SW = $clog2(STABLE_LINES + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state;
  logic          hs_d;
  logic          hs_edge;
  logic [CW-1:0] cnt;
  logic [CW-1:0] p_last;
  logic [CW-1:0] diff;
  logic [SW-1:0] stable_cnt;
  logic [SW-1:0] stable_nxt;
  logic [3:0]    pending;
  logic          edge_ok;
  logic          timeout;
  logic          qualify;
  logic          start;
  logic          done;
  logic [3:0]    d_found;

  assign hs_edge = hs_d & ~hs_in;
  assign timeout = !hs_edge && (cnt == CNT_MAX);
  assign diff    = (cnt > p_last) ? cnt - p_last : p_last - cnt;
  assign edge_ok = (cnt >= CW'(MIN_LINE)) && (diff <= CW'(TOL));

`ifdef SD_DIVCTRL_VB_GATE_EN
  assign qualify = vb_in;
`else
  logic unused_vb;
  assign unused_vb = vb_in;
  assign qualify   = 1'b1;
`endif

  // NOTE: default first, so every path assigns stable_nxt and no latch is inferred.
  always_comb begin
    stable_nxt = stable_cnt;
    if (cnt < CW'(MIN_LINE)) begin
      stable_nxt = '0;
    end else if (diff <= CW'(TOL)) begin
      if (stable_cnt != SW'(STABLE_LINES)) stable_nxt = stable_cnt + SW'(1);
    end else begin
      stable_nxt = SW'(1);
    end
  end

  assign start = hs_edge && (state == MEASURE) && (stable_nxt == SW'(STABLE_LINES));

  sd_div_search #(
    .PW              (CW),
    .LINE_PIXELS_MAX (LINE_PIXELS_MAX),
    .MIN_DIV         (MIN_DIV),
    .MAX_DIV         (MAX_DIV)
  ) u_search (
    .clk   (clk_sys),
    .rst   (reset),
    .start (start),
    .abort (state != SEARCH),
    .ps    (cnt),
    .done  (done),
    .d_out (d_found)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state       <= NOSIG;
      hs_d        <= 1'b0;
      cnt         <= '0;
      p_last      <= '0;
      stable_cnt  <= '0;
      pending     <= 4'(DEF_DIV);
      ce_divider  <= 4'(DEF_DIV);
      locked      <= 1'b0;
      no_signal   <= 1'b1;
      line_len    <= '0;
      div_changed <= 1'b0;
    end else begin
      hs_d        <= hs_in;
      div_changed <= 1'b0;
      if (hs_edge) cnt <= CW'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + CW'(1);

      if (hs_edge) begin
        line_len <= cnt;
        p_last   <= cnt;
        if (state == NOSIG) begin
          // The first period after loss of signal has no valid predecessor to compare against.
          state     <= MEASURE;
          no_signal <= 1'b0;
        end else begin
          stable_cnt <= stable_nxt;
          if (!edge_ok && state != MEASURE) begin
            state  <= MEASURE;
            locked <= 1'b0;
          end else if (start) begin
            state <= SEARCH;
          end else if (state == APPLY && qualify) begin
            ce_divider  <= pending;
            div_changed <= 1'b1;
            state       <= LOCKED;
            locked      <= 1'b1;
          end
        end
      end else if (timeout) begin
        state      <= NOSIG;
        locked     <= 1'b0;
        no_signal  <= 1'b1;
        stable_cnt <= '0;
      end

      if (state == SEARCH && done && !timeout && !(hs_edge && !edge_ok)) begin
        if (d_found == ce_divider) begin
          state  <= LOCKED;
          locked <= 1'b1;
        end else begin
          pending <= d_found;
          state   <= APPLY;
        end
      end
    end
  end

endmodule

// File: tb/tb_scandoubler_divider_ctrl.sv
// Self-checking bench for scandoubler_divider_ctrl: cycle model from the behavioural rules plus directed literals.
module tb_scandoubler_divider_ctrl;

  localparam int LPM     = 512;
  localparam int MIN_DIV = 1;
  localparam int MAX_DIV = 15;
  localparam int MIN_LN  = 32;
  localparam int TOL     = 4;
  localparam int STABLE  = 4;
  localparam int CMAX    = 8191;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        hs_in   = 1'b0;
  logic        vb_in   = 1'b0;
  logic [3:0]  ce_divider;
  logic        locked;
  logic        no_signal;
  logic [12:0] line_len;
  logic        div_changed;

  int n_cmp = 0;
  int n_bad = 0;
  int dc_cycles = 0;

  always #5 clk_sys = ~clk_sys;

  scandoubler_divider_ctrl dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .hs_in       (hs_in),
    .vb_in       (vb_in),
    .ce_divider  (ce_divider),
    .locked      (locked),
    .no_signal   (no_signal),
    .line_len    (line_len),
    .div_changed (div_changed)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_NOSIG, M_MEASURE, M_SEARCH, M_APPLY, M_LOCKED} mstate_e;
  mstate_e m_st;
  int m_cnt, m_plast, m_stab, m_ce, m_pend, m_len, m_wait, m_target;
  bit m_hsd, m_dc;

  function automatic int best_div(input int p);
    for (int d = MIN_DIV; d < MAX_DIV; d++)
      if (LPM * (d + 1) > p) return d;
    return MAX_DIV;
  endfunction

  task automatic model_reset();
    m_st = M_NOSIG; m_cnt = 0; m_plast = 0; m_stab = 0; m_ce = 3;
    m_pend = 3; m_len = 0; m_wait = 0; m_target = 0; m_hsd = 0; m_dc = 0;
  endtask

  task automatic model_step();
    bit e, ok, qual;
    int p;
    mstate_e s0;
    s0 = m_st;
    e = m_hsd && !hs_in;
    m_hsd = hs_in;
    p = m_cnt;
    m_dc = 0;
`ifdef SD_DIVCTRL_VB_GATE_EN
    qual = vb_in;
`else
    qual = 1;
`endif
    if (e) begin
      m_cnt = 1;
      m_len = p;
      if (m_st == M_NOSIG) m_st = M_MEASURE;
      else begin
        ok = (p >= MIN_LN) && (((p > m_plast) ? p - m_plast : m_plast - p) <= TOL);
        if (p < MIN_LN) m_stab = 0;
        else if (ok) m_stab = (m_stab + 1 > STABLE) ? STABLE : m_stab + 1;
        else m_stab = 1;
        if (!ok && m_st != M_MEASURE) m_st = M_MEASURE;
        else if (m_st == M_MEASURE && m_stab == STABLE) begin
          m_st = M_SEARCH;
          m_target = best_div(p);
          m_wait = m_target - MIN_DIV + 1;
        end else if (m_st == M_APPLY && qual) begin
          m_ce = m_pend; m_dc = 1; m_st = M_LOCKED;
        end
      end
      m_plast = p;
    end else if (m_cnt == CMAX) begin
      m_st = M_NOSIG; m_stab = 0;
    end else m_cnt++;
    if (s0 == M_SEARCH && m_st == M_SEARCH) begin
      m_wait--;
      if (m_wait == 0) begin
        if (m_target == m_ce) m_st = M_LOCKED;
        else begin m_pend = m_target; m_st = M_APPLY; end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_sys);
      if (reset) model_reset();
      else model_step();
    end
  end

  // Compare process: DUT outputs settle after posedge; sample on negedge.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (div_changed === 1'b1) dc_cycles++;
      if (!reset) begin
        check("ce_divider",  32'(ce_divider),  32'(m_ce));
        check("locked",      32'(locked),      32'(m_st == M_LOCKED));
        check("no_signal",   32'(no_signal),   32'(m_st == M_NOSIG));
        check("line_len",    32'(line_len),    32'(m_len));
        check("div_changed", 32'(div_changed), 32'(m_dc));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    reset = 1'b1; hs_in = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
  endtask

  // One hsync period of n cycles: falling edges of consecutive calls land n cycles apart.
  task automatic hs_line(input int n);
    hs_in = 1'b1;
    @(negedge clk_sys);
    hs_in = 1'b0;
    repeat (n - 1) @(negedge clk_sys);
  endtask

  int dc0;

  initial begin
    @(negedge clk_sys);
    do_reset();

    // 1: no hsync at all
    check("t1 reset ce", 32'(ce_divider), 3);
    check("t1 reset no_signal", 32'(no_signal), 1);
    check("t1 reset line_len", 32'(line_len), 0);
    repeat (9000) @(negedge clk_sys);
    check("t1 idle ce", 32'(ce_divider), 3);
    check("t1 idle no_signal", 32'(no_signal), 1);
    check("t1 idle locked", 32'(locked), 0);
    check("t1 idle div_changed count", 32'(dc_cycles), 0);

    // 2: 1024-cycle lines pick divider 2
    dc0 = dc_cycles;
    repeat (6) hs_line(1024);
    check("t2 ce", 32'(ce_divider), 2);
    check("t2 locked", 32'(locked), 1);
    check("t2 line_len", 32'(line_len), 1024);
    check("t2 div_changed cycles", 32'(dc_cycles - dc0), 1);

    // 3: 1000-cycle lines from reset, tolerance and re-measure
    do_reset();
    dc0 = dc_cycles;
    repeat (6) hs_line(1000);
    check("t3 ce", 32'(ce_divider), 1);
    check("t3 locked", 32'(locked), 1);
    check("t3 div_changed cycles", 32'(dc_cycles - dc0), 1);
    hs_line(1002);
    hs_line(1010);
    check("t3 within tol locked", 32'(locked), 1);
    hs_line(1010);
    check("t3 out of tol unlocked", 32'(locked), 0);
    repeat (4) hs_line(1010);
    check("t3 relocked", 32'(locked), 1);
    check("t3 ce kept", 32'(ce_divider), 1);
    check("t3 no extra div_changed", 32'(dc_cycles - dc0), 1);

    // 4: loss of hsync while locked
    do_reset();
    repeat (6) hs_line(1024);
    check("t4 locked before loss", 32'(locked), 1);
    repeat (8200) @(negedge clk_sys);
    check("t4 no_signal", 32'(no_signal), 1);
    check("t4 locked", 32'(locked), 0);
    check("t4 ce held", 32'(ce_divider), 2);

    // 5: glitch pulse forces STABLE fresh periods
    repeat (6) hs_line(1024);
    check("t5 locked", 32'(locked), 1);
    hs_line(10);
    hs_line(1014);
    check("t5 glitch unlock", 32'(locked), 0);
    check("t5 glitch line_len", 32'(line_len), 10);
    repeat (4) hs_line(1024);
    check("t5 still measuring", 32'(locked), 0);
    hs_line(1024);
    check("t5 relocked", 32'(locked), 1);
    check("t5 ce", 32'(ce_divider), 2);

    // 6: vblank gating of the apply edge
    do_reset();
    vb_in = 1'b0;
    dc0 = dc_cycles;
    repeat (6) hs_line(1024);
`ifdef SD_DIVCTRL_VB_GATE_EN
    repeat (2) hs_line(1024);
    check("t6 held in active", 32'(ce_divider), 3);
    check("t6 not locked", 32'(locked), 0);
    check("t6 no pulse", 32'(dc_cycles - dc0), 0);
    vb_in = 1'b1;
    hs_line(1024);
    vb_in = 1'b0;
`endif
    check("t6 ce applied", 32'(ce_divider), 2);
    check("t6 locked", 32'(locked), 1);
    check("t6 one pulse", 32'(dc_cycles - dc0), 1);

    repeat (5) @(negedge clk_sys);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
